// File: rtl/vx_gpu_pkg.sv
// Shared GPU definitions: Avalon burst-responder state encoding and ROB index sizing.
package vx_gpu_pkg;

  // Avalon slave burst tracking states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } avs_burst_state_e;

  // ROB index width for the default 16-slot read queue
  localparam int unsigned ROB_IDX_W = 4;

  // Index width for an arbitrary ROB depth (at least 1 bit)
  function automatic int unsigned rob_idx_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/vx_pending_size.sv
// Outstanding-entry counter with a registered full flag.
// Ports: clk, reset (async, active-high); incr/decr pulse once per
// allocation/release (both together leave the count unchanged); full is high
// while the count equals SIZE.
module vx_pending_size #(
  parameter int unsigned SIZE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic incr,
  input  logic decr,
  output logic full
);

  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  // Next count; full is derived from the next count so it is registered
  always_comb begin
    count_d = count_q;
    if (incr && !decr) begin
      count_d = count_q + CNT_W'(1);
    end else if (decr && !incr) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d = (count_d == CNT_W'(SIZE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign full = full_q;

endmodule

// File: rtl/vx_avs_responder.sv
// Avalon-MM slave to tagged memory request/response bridge with an in-order
// read reorder buffer.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   avs_* (in)                  - Avalon-MM slave command/write data
//   avs_waitrequest (comb)      - stall toward the Avalon host
//   avs_readdata/readdatavalid  - registered in-order read returns
//   mem_req_* (comb)            - memory request channel, tag = ROB slot
//   mem_rsp_*                   - memory responses (any order), always ready
module vx_avs_responder
  import vx_gpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH    = 26,
  parameter int unsigned BURST_WIDTH   = 4,
  parameter int unsigned RD_QUEUE_SIZE = 16,
  parameter int unsigned TAG_WIDTH     = $clog2(RD_QUEUE_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [ADDR_WIDTH-1:0]   avs_address,
  input  logic [DATA_WIDTH-1:0]   avs_writedata,
  input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
  input  logic [BURST_WIDTH-1:0]  avs_burstcount,
  output logic                    avs_waitrequest,
  output logic [DATA_WIDTH-1:0]   avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  output logic [TAG_WIDTH-1:0]    mem_req_tag,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  output logic                    mem_rsp_ready
);

  localparam int unsigned IDX_W = rob_idx_width(RD_QUEUE_SIZE);

  avs_burst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [BURST_WIDTH-1:0]    remaining_q, remaining_d;
  logic [IDX_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [RD_QUEUE_SIZE-1:0]  valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     readdata_q, readdata_d;
  logic                      readdatavalid_q, readdatavalid_d;
  logic [DATA_WIDTH-1:0]     rob_mem [RD_QUEUE_SIZE];

  logic                      rob_full;
  logic                      rd_fire;
  logic                      retire;
  logic [BURST_WIDTH-1:0]    burst_len;
  logic [IDX_W-1:0]          rsp_idx;

  // A burstcount of zero is a single beat
  assign burst_len = (avs_burstcount == '0) ? BURST_WIDTH'(1) : avs_burstcount;
  assign rsp_idx   = IDX_W'(mem_rsp_tag);

  // Burst FSM: next state and combinational request/waitrequest
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    rd_fire         = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = addr_q;
    mem_req_data    = '0;
    mem_req_byteen  = '1;
    avs_waitrequest = 1'b1;

    case (state_q)
      IDLE: begin
        avs_waitrequest = 1'b0;
        if (avs_write) begin
          mem_req_valid   = 1'b1;
          mem_req_rw      = 1'b1;
          mem_req_addr    = avs_address;
          mem_req_data    = avs_writedata;
          mem_req_byteen  = avs_byteenable;
          avs_waitrequest = !mem_req_ready;
          if (mem_req_ready && (burst_len > BURST_WIDTH'(1))) begin
            state_d     = WR_BURST;
            addr_d      = avs_address + ADDR_WIDTH'(1);
            remaining_d = burst_len - BURST_WIDTH'(1);
          end
        end else if (avs_read) begin
          // Beat 0 goes out with the command; a ROB slot must be free
          mem_req_valid   = !rob_full;
          mem_req_addr    = avs_address;
          avs_waitrequest = !mem_req_ready || rob_full;
          if (mem_req_ready && !rob_full) begin
            rd_fire = 1'b1;
            if (burst_len > BURST_WIDTH'(1)) begin
              state_d     = RD_BURST;
              addr_d      = avs_address + ADDR_WIDTH'(1);
              remaining_d = burst_len - BURST_WIDTH'(1);
            end
          end
        end
      end

      RD_BURST: begin
        mem_req_valid = !rob_full;
        if (mem_req_ready && !rob_full) begin
          rd_fire     = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - BURST_WIDTH'(1);
          if (remaining_q == BURST_WIDTH'(1)) begin
            state_d = IDLE;
          end
        end
      end

      WR_BURST: begin
        mem_req_valid   = avs_write;
        mem_req_rw      = 1'b1;
        mem_req_data    = avs_writedata;
        mem_req_byteen  = avs_byteenable;
        avs_waitrequest = !mem_req_ready;
        if (avs_write && mem_req_ready) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - BURST_WIDTH'(1);
          if (remaining_q == BURST_WIDTH'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset is asynchronous, so the combinational side is masked too
    if (reset) begin
      mem_req_valid   = 1'b0;
      avs_waitrequest = 1'b1;
      rd_fire         = 1'b0;
    end
  end

  // ROB bookkeeping: allocate on read issue, fill on response, retire in order
  always_comb begin
    retire          = valid_q[rd_ptr_q];
    wr_ptr_d        = rd_fire ? (wr_ptr_q + IDX_W'(1)) : wr_ptr_q;
    rd_ptr_d        = retire ? (rd_ptr_q + IDX_W'(1)) : rd_ptr_q;
    valid_d         = valid_q;
    readdatavalid_d = retire;
    readdata_d      = retire ? rob_mem[rd_ptr_q] : readdata_q;
    if (retire) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (mem_rsp_valid) begin
      valid_d[rsp_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      valid_q         <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      valid_q         <= valid_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  // ROB data storage; contents are qualified by valid_q, so no reset
  always_ff @(posedge clk) begin
    if (mem_rsp_valid) begin
      rob_mem[rsp_idx] <= mem_rsp_data;
    end
  end

  vx_pending_size #(
    .SIZE (RD_QUEUE_SIZE)
  ) u_pending_size (
    .clk   (clk),
    .reset (reset),
    .incr  (rd_fire),
    .decr  (retire),
    .full  (rob_full)
  );

  assign mem_req_tag       = TAG_WIDTH'(wr_ptr_q);
  assign mem_rsp_ready     = 1'b1;
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_vx_avs_responder.sv
// Directed bench for vx_avs_responder with a 4-slot ROB and 26-bit addresses.
module tb_vx_avs_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int unsigned BW = 4;
  localparam int unsigned QS = 4;
  localparam int unsigned TW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            avs_read, avs_write;
  logic [AW-1:0]   avs_address;
  logic [DW-1:0]   avs_writedata;
  logic [DW/8-1:0] avs_byteenable;
  logic [BW-1:0]   avs_burstcount;
  logic            avs_waitrequest;
  logic [DW-1:0]   avs_readdata;
  logic            avs_readdatavalid;
  logic            mem_req_valid, mem_req_rw;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic [TW-1:0]   mem_rsp_tag;
  logic            mem_rsp_ready;

  vx_avs_responder #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .BURST_WIDTH   (BW),
    .RD_QUEUE_SIZE (QS),
    .TAG_WIDTH     (TW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_address       (avs_address),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .mem_req_valid     (mem_req_valid),
    .mem_req_rw        (mem_req_rw),
    .mem_req_byteen    (mem_req_byteen),
    .mem_req_addr      (mem_req_addr),
    .mem_req_data      (mem_req_data),
    .mem_req_tag       (mem_req_tag),
    .mem_req_ready     (mem_req_ready),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .mem_rsp_tag       (mem_rsp_tag),
    .mem_rsp_ready     (mem_rsp_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  logic [DW-1:0] rdv_q [$];

  // Record every returned read beat
  always @(negedge clk) begin
    if (avs_readdatavalid) rdv_q.push_back(avs_readdata);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rsp(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = tag;
    mem_rsp_data  = data;
    cyc(1);
    mem_rsp_valid = 1'b0;
  endtask

  task automatic check_rdv(input string tag, input int idx, input logic [DW-1:0] exp);
    check_eq(tag, (idx < rdv_q.size()) ? 64'(rdv_q[idx]) : 64'hDEAD_0000_0000_0000, 64'(exp));
  endtask

  logic [AW-1:0] burst_addr [3] = '{26'h3FFFFFF, 26'h0000000, 26'h0000001};
  logic [TW-1:0] burst_tag  [3] = '{2'd2, 2'd3, 2'd0};
  logic [TW-1:0] ooo_tag    [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
  logic [DW-1:0] ooo_data   [4] = '{32'hB3, 32'hB1, 32'hB0, 32'hB2};
  logic          wr_rdy     [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [DW-1:0] wr_dat     [4] = '{32'h1111_1111, 32'h2222_2222, 32'h2222_2222, 32'h3333_3333};
  logic [AW-1:0] wr_addr    [4] = '{26'h20, 26'h21, 26'h21, 26'h22};
  logic          wr_wait    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  int base;

  initial begin
    reset          = 1'b1;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_address    = '0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    avs_burstcount = '0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    mem_rsp_tag    = '0;
    #2;
    check_eq("rst_waitreq", 64'(avs_waitrequest), 64'h1);
    check_eq("rst_reqvalid", 64'(mem_req_valid), 64'h0);
    check_eq("rst_rdv", 64'(avs_readdatavalid), 64'h0);
    check_eq("rst_rdata", 64'(avs_readdata), 64'h0);
    check_eq("rsp_ready", 64'(mem_rsp_ready), 64'h1);
    cyc(2);
    reset = 1'b0;

    // Single read at 0x10, response after 3 cycles
    cyc(1);
    avs_read = 1'b1; avs_address = 26'h10; avs_burstcount = 4'd1;
    #1;
    check_eq("rd1_valid", 64'(mem_req_valid), 64'h1);
    check_eq("rd1_rw", 64'(mem_req_rw), 64'h0);
    check_eq("rd1_addr", 64'(mem_req_addr), 64'h10);
    check_eq("rd1_tag", 64'(mem_req_tag), 64'h0);
    check_eq("rd1_wait", 64'(avs_waitrequest), 64'h0);
    cyc(1);
    avs_read = 1'b0;
    #1;
    check_eq("rd1_idle", 64'(mem_req_valid), 64'h0);
    cyc(2);
    rsp(2'd0, 32'hA5);
    check_eq("rd1_lat1", 64'(avs_readdatavalid), 64'h0);
    cyc(1);
    check_eq("rd1_rdv", 64'(avs_readdatavalid), 64'h1);
    check_eq("rd1_data", 64'(avs_readdata), 64'hA5);
    cyc(1);
    check_eq("rd1_pulse", 64'(avs_readdatavalid), 64'h0);

    // Read burst of 4 wrapping the address space; responses out of order
    base = rdv_q.size();
    avs_read = 1'b1; avs_address = 26'h3FFFFFE; avs_burstcount = 4'd4;
    #1;
    check_eq("brst_addr0", 64'(mem_req_addr), 64'h3FFFFFE);
    check_eq("brst_tag0", 64'(mem_req_tag), 64'h1);
    check_eq("brst_wait0", 64'(avs_waitrequest), 64'h0);
    cyc(1);
    avs_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("brst_valid", 64'(mem_req_valid), 64'h1);
      check_eq("brst_addr", 64'(mem_req_addr), 64'(burst_addr[k]));
      check_eq("brst_tag", 64'(mem_req_tag), 64'(burst_tag[k]));
      check_eq("brst_wait", 64'(avs_waitrequest), 64'h1);
      cyc(1);
    end
    #1;
    check_eq("brst_done", 64'(mem_req_valid), 64'h0);
    check_eq("brst_wait_end", 64'(avs_waitrequest), 64'h0);
    for (int k = 0; k < 4; k++) rsp(ooo_tag[k], ooo_data[k]);
    cyc(6);
    check_eq("ooo_count", 64'(rdv_q.size()), 64'(base + 4));
    for (int k = 0; k < 4; k++) check_rdv("ooo_order", base + k, DW'(32'hB0 + k));

    // Write burst of 3 at 0x20 with ready 1,0,1,1; read asserted too
    base = rdv_q.size();
    avs_write = 1'b1; avs_read = 1'b1; avs_address = 26'h20;
    avs_burstcount = 4'd3; avs_byteenable = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      mem_req_ready = wr_rdy[k];
      avs_writedata = wr_dat[k];
      #1;
      check_eq("wr_valid", 64'(mem_req_valid), 64'h1);
      check_eq("wr_rw", 64'(mem_req_rw), 64'h1);
      check_eq("wr_addr", 64'(mem_req_addr), 64'(wr_addr[k]));
      check_eq("wr_data", 64'(mem_req_data), 64'(wr_dat[k]));
      check_eq("wr_wait", 64'(avs_waitrequest), 64'(wr_wait[k]));
      check_eq("wr_byteen", 64'(mem_req_byteen), 64'hA);
      cyc(1);
      avs_address = 26'h155;
    end
    avs_write = 1'b0; avs_read = 1'b0; mem_req_ready = 1'b1;
    #1;
    check_eq("wr_done", 64'(mem_req_valid), 64'h0);
    cyc(4);
    check_eq("wr_no_rdv", 64'(rdv_q.size()), 64'(base));

    // Fresh reset, then ROB-full stall on the 5th read beat
    reset = 1'b1;
    #1;
    check_eq("rst2_rdata", 64'(avs_readdata), 64'h0);
    check_eq("rst2_wait", 64'(avs_waitrequest), 64'h1);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    base = rdv_q.size();
    avs_read = 1'b1; avs_address = 26'h40; avs_burstcount = 4'd5;
    #1;
    check_eq("full_tag0", 64'(mem_req_tag), 64'h0);
    cyc(1);
    avs_read = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check_eq("full_tagk", 64'(mem_req_tag), 64'(k));
      check_eq("full_addrk", 64'(mem_req_addr), 64'(26'h40 + k));
      cyc(1);
    end
    #1;
    check_eq("full_stall", 64'(mem_req_valid), 64'h0);
    check_eq("full_wait", 64'(avs_waitrequest), 64'h1);
    cyc(1);
    check_eq("full_stall2", 64'(mem_req_valid), 64'h0);
    rsp(2'd0, 32'hC0);
    #1;
    check_eq("full_stall3", 64'(mem_req_valid), 64'h0);
    cyc(1);
    check_eq("full_go", 64'(mem_req_valid), 64'h1);
    check_eq("full_go_tag", 64'(mem_req_tag), 64'h0);
    check_eq("full_go_addr", 64'(mem_req_addr), 64'h44);
    check_eq("full_go_wait", 64'(avs_waitrequest), 64'h1);
    cyc(1);
    check_eq("full_idle", 64'(mem_req_valid), 64'h0);
    rsp(2'd1, 32'hC1);
    rsp(2'd2, 32'hC2);
    rsp(2'd3, 32'hC3);
    rsp(2'd0, 32'hC4);
    cyc(5);
    check_eq("full_count", 64'(rdv_q.size()), 64'(base + 5));
    for (int k = 0; k < 5; k++) check_rdv("full_order", base + k, DW'(32'hC0 + k));

    // Reset in the middle of an 8-beat read burst
    avs_read = 1'b1; avs_address = 26'h80; avs_burstcount = 4'd8;
    #1;
    check_eq("mid_tag0", 64'(mem_req_tag), 64'h1);
    cyc(1);
    avs_read = 1'b0;
    #1;
    check_eq("mid_addr1", 64'(mem_req_addr), 64'h81);
    cyc(1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(mem_req_valid), 64'h0);
    check_eq("mid_rst_wait", 64'(avs_waitrequest), 64'h1);
    check_eq("mid_rst_rdata", 64'(avs_readdata), 64'h0);
    cyc(1);
    reset = 1'b0;
    #1;
    check_eq("mid_abandon", 64'(mem_req_valid), 64'h0);
    cyc(1);
    check_eq("mid_abandon2", 64'(mem_req_valid), 64'h0);
    base = rdv_q.size();
    avs_read = 1'b1; avs_address = 26'h90; avs_burstcount = 4'd0;
    #1;
    check_eq("post_tag", 64'(mem_req_tag), 64'h0);
    check_eq("post_addr", 64'(mem_req_addr), 64'h90);
    cyc(1);
    avs_read = 1'b0;
    #1;
    check_eq("bc0_single", 64'(mem_req_valid), 64'h0);
    rsp(2'd0, 32'h5A);
    cyc(1);
    check_eq("post_rdv", 64'(avs_readdatavalid), 64'h1);
    check_eq("post_data", 64'(avs_readdata), 64'h5A);
    cyc(3);
    check_eq("post_count", 64'(rdv_q.size()), 64'(base + 1));
    check_eq("total_rdv", 64'(rdv_q.size()), 64'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vx_avs_responder.md
VX_AVS_RESPONDER -- requirements
Module: VX_avs_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: data bus width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 26: word address width.
REQ-003 SHALL have parameter BURST_WIDTH, default 4: avs_burstcount width.
REQ-004 SHALL have parameter RD_QUEUE_SIZE, default 16: reorder slots, a power of 2 and at least 2.
REQ-005 SHALL have parameter TAG_WIDTH, default log2(RD_QUEUE_SIZE): mem tag width.
REQ-006 SHALL have clk, input, 1 bit: the single clock.
REQ-007 SHALL have reset, input, 1 bit: asynchronous, active-high.
REQ-008 SHALL have these Avalon-MM slave inputs: avs_read (1), avs_write (1), avs_address (ADDR_WIDTH), avs_writedata (DATA_WIDTH), avs_byteenable (DATA_WIDTH/8), avs_burstcount (BURST_WIDTH).
REQ-009 SHALL have these Avalon-MM slave outputs: avs_waitrequest (1), avs_readdata (DATA_WIDTH), avs_readdatavalid (1).
REQ-010 SHALL have these memory request outputs: mem_req_valid (1), mem_req_rw (1), mem_req_byteen (DATA_WIDTH/8), mem_req_addr (ADDR_WIDTH), mem_req_data (DATA_WIDTH), mem_req_tag (TAG_WIDTH); input mem_req_ready (1).
REQ-011 SHALL have these memory response inputs: mem_rsp_valid (1), mem_rsp_data (DATA_WIDTH), mem_rsp_tag (TAG_WIDTH); output mem_rsp_ready (1).

Function
REQ-012 SHALL implement FSM states IDLE, RD_BURST and WR_BURST.
REQ-013 SHALL accept a command in IDLE when (avs_read or avs_write) and !avs_waitrequest, sampling address and burstcount only on that cycle.
REQ-014 SHALL treat a burstcount of 0 as 1.
REQ-015 SHALL give avs_write priority over avs_read when both are asserted.
REQ-016 IDLE read: SHALL issue beat 0 in the same cycle; avs_waitrequest = !mem_req_ready || rob_full.
REQ-017 IDLE read: SHALL go to RD_BURST with remaining = burstcount-1 and addr+1 if burstcount>1, else stay in IDLE.
REQ-018 RD_BURST: SHALL hold avs_waitrequest=1.
REQ-019 RD_BURST: SHALL issue one read beat per cycle when mem_req_ready && !rob_full, then return to IDLE after the last beat handshake.
REQ-020 Write: SHALL pass each avs_write beat combinationally to mem_req (rw=1, byteen, data) with avs_waitrequest = !mem_req_ready.
REQ-021 Write: SHALL stay in WR_BURST for the remaining beats, addressing each beat from the latched, incrementing address; avs_read SHALL be ignored in WR_BURST.
REQ-022 SHALL increment addresses by 1 per beat, wrapping modulo 2^ADDR_WIDTH.
REQ-023 SHALL set the read tag to the ROB allocation pointer; the pointer advances by 1 per read handshake and wraps at RD_QUEUE_SIZE.
REQ-024 SHALL drive mem_rsp_ready constantly 1, since a slot is reserved per read.
REQ-025 On a mem response, SHALL write data[tag] and set valid[tag]=1.
REQ-026 SHALL retire in order: when valid[rd_ptr], register avs_readdata and avs_readdatavalid=1 the next cycle, clear valid, and advance rd_ptr.
REQ-027 Minimum response latency SHALL be 2 cycles from mem_rsp to avs_readdatavalid, and retirement SHALL be at most 1 per cycle.
REQ-028 A response arriving for the rd_ptr slot SHALL retire no earlier than the following cycle.
REQ-029 rob_full SHALL be occupancy==RD_QUEUE_SIZE.
REQ-030 Occupancy SHALL hold when allocate and retire occur in the same cycle.
REQ-031 When full, new reads SHALL stall while writes still proceed.
REQ-032 Writes SHALL generate no avs_readdatavalid.

Reset
REQ-033 Asynchronous reset SHALL force IDLE, pointers and occupancy to 0, all valid bits to 0, avs_readdatavalid=0 and avs_readdata=0.
REQ-034 Under reset, combinational outputs SHALL present mem_req_valid=0 and avs_waitrequest=1.
REQ-035 Reset mid-burst SHALL abandon the burst with no further beats issued.
REQ-036 The memory side SHALL be reset concurrently; stale responses after reset are unsupported.

Structure
REQ-037 The burst state enum and a ROB index width constant SHALL live in the shared VX_gpu_pkg.
REQ-038 Occupancy SHALL use the existing VX_pending_size sub-module (SIZE=RD_QUEUE_SIZE).
REQ-039 ROB data storage SHALL be a flat register/RAM array inside the module.

Verification
REQ-040 Single read at addr 0x10, memory returning 0xA5 after 3 cycles -> mem_req addr=0x10, tag=0; avs_readdatavalid pulses once with 0xA5.
REQ-041 Read burst of 4 at 0x3FFFFFE (ADDR_WIDTH=26), mem_req_ready always 1 -> addrs 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x1 on consecutive cycles; waitrequest high for 3 cycles.
REQ-042 Burst of 4 with responses returned in tag order 3,1,0,2 -> avs_readdata order is beats 0,1,2,3; readdatavalid count = 4.
REQ-043 Write burst of 3 at 0x20 with mem_req_ready toggling 1,0,1,1 -> beats at 0x20, 0x21, 0x22; waitrequest mirrors !ready; no readdatavalid.
REQ-044 RD_QUEUE_SIZE=4 with memory withholding responses -> the 5th read beat stalls (waitrequest=1) until 1 retirement, then proceeds with tag 0.
REQ-045 Reset asserted mid read burst after 2 of 8 beats -> outputs go to reset values asynchronously; after release, a new single read gets tag 0 and completes.
